// File: rtl/friscv_pkg.sv
// Shared decode definitions: opcode constants, format tag and the decoded bundle layout.
package friscv_pkg;

    localparam int ARCH          = 32;
    localparam int REGFILE_DEPTH = 32;
    localparam int REG_IDX_W     = $clog2(REGFILE_DEPTH);

    localparam logic [6:0] REG       = 7'b0110011;
    localparam logic [6:0] IMM_ARITH = 7'b0010011;
    localparam logic [6:0] IMM_LOAD  = 7'b0000011;
    localparam logic [6:0] IMM_JUMP  = 7'b1100111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;
    localparam logic [6:0] FENCE     = 7'b0001111;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JUMP      = 7'b1101111;

    // TYPE_NONE is zero so an all-zero bundle is the reset / illegal shape.
    typedef enum logic [2:0] {
        TYPE_NONE = 3'd0,
        TYPE_R    = 3'd1,
        TYPE_I    = 3'd2,
        TYPE_S    = 3'd3,
        TYPE_B    = 3'd4,
        TYPE_U    = 3'd5,
        TYPE_J    = 3'd6
    } instr_type_t;

    // Decoded bundle at the default ARCH / REGFILE_DEPTH.
    typedef struct packed {
        logic [6:0]           op_code;
        logic [2:0]           func3;
        logic [6:0]           func7;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic [ARCH-1:0]      imm;
        logic [ARCH-1:0]      pc;
        instr_type_t          instr_type;
        logic                 illegal;
    } dec_bundle_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: builds the format-specific immediate, sign-extended from bit 31.
module imm_gen
    import friscv_pkg::*;
#(
    parameter int ARCH = friscv_pkg::ARCH
) (
    input  logic [31:7]     instr_in,
    input  instr_type_t     instr_type,
    output logic [ARCH-1:0] imm_out
);

    logic [31:0] imm32;

    // Assemble the 32-bit immediate for the given format; R and NONE yield zero.
    always_comb begin
        imm32 = '0;
        case (instr_type)
            TYPE_I: imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
            TYPE_S: imm32 = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            TYPE_B: imm32 = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                             instr_in[30:25], instr_in[11:8], 1'b0};
            TYPE_U: imm32 = {instr_in[31:12], 12'b0};
            TYPE_J: imm32 = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                             instr_in[20], instr_in[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed size cast widens to ARCH with sign extension when ARCH is 64.
    assign imm_out = ARCH'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I/RV32E decode stage: combinational classify/extract, then output register + skid entry.
module decode_stage
    import friscv_pkg::*;
#(
    parameter int ARCH          = friscv_pkg::ARCH,
    parameter int REGFILE_DEPTH = friscv_pkg::REGFILE_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush_in,
    input  logic                             instr_valid_in,
    output logic                             instr_ready_out,
    input  logic [31:0]                      instr_in,
    input  logic [ARCH-1:0]                  pc_in,
    output logic                             dec_valid_out,
    input  logic                             dec_ready_in,
    output logic [6:0]                       op_code_out,
    output logic [2:0]                       func3_out,
    output logic [6:0]                       func7_out,
    output logic [$clog2(REGFILE_DEPTH)-1:0] rs1_out,
    output logic [$clog2(REGFILE_DEPTH)-1:0] rs2_out,
    output logic [$clog2(REGFILE_DEPTH)-1:0] rd_out,
    output logic [ARCH-1:0]                  imm_out,
    output instr_type_t                      instr_type_out,
    output logic                             illegal_out,
    output logic [ARCH-1:0]                  pc_out
);

    localparam int RW = $clog2(REGFILE_DEPTH);

    typedef struct packed {
        logic [6:0]      op_code;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [RW-1:0]   rd;
        logic [ARCH-1:0] imm;
        logic [ARCH-1:0] pc;
        instr_type_t     instr_type;
        logic            illegal;
    } bundle_t;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits for ready, and a producer holds its payload stable while valid & !ready.

    logic [6:0]      op;
    logic [2:0]      f3;
    logic [6:0]      f7;
    instr_type_t     raw_type;
    logic            known;
    logic            use_rd, use_rs1, use_rs2, use_f3, use_f7;
    logic            reg_hi_bad;
    logic            illegal;
    logic [ARCH-1:0] raw_imm;
    bundle_t         dec;

    bundle_t or_q, sk_q;
    logic    or_valid, sk_valid;
    logic    accept;

    assign op = instr_in[6:0];
    assign f3 = instr_in[14:12];
    assign f7 = instr_in[31:25];

    // Classify the opcode into a format and derive the illegal-instruction flag.
    always_comb begin
        raw_type = TYPE_NONE;
        known    = 1'b1;
        case (op)
            REG:                                      raw_type = TYPE_R;
            IMM_ARITH, IMM_LOAD, IMM_JUMP, SYSTEM, FENCE: raw_type = TYPE_I;
            STORE:                                    raw_type = TYPE_S;
            BRANCH:                                   raw_type = TYPE_B;
            LUI, AUIPC:                               raw_type = TYPE_U;
            JUMP:                                     raw_type = TYPE_J;
            default:                                  known    = 1'b0;
        endcase

        use_rd  = raw_type inside {TYPE_R, TYPE_I, TYPE_U, TYPE_J};
        use_rs1 = raw_type inside {TYPE_R, TYPE_I, TYPE_S, TYPE_B};
        use_rs2 = raw_type inside {TYPE_R, TYPE_S, TYPE_B};
        use_f3  = raw_type inside {TYPE_R, TYPE_I, TYPE_S, TYPE_B};
        use_f7  = (raw_type == TYPE_R);

        // RV32E has only x0..x15, so bit 4 of any referenced register index is out of range.
        reg_hi_bad = (REGFILE_DEPTH == 16) &&
                     ((use_rd && instr_in[11]) || (use_rs1 && instr_in[19]) ||
                      (use_rs2 && instr_in[24]));

        illegal = (instr_in[1:0] != 2'b11) || !known ||
                  ((op == IMM_JUMP) && (f3 != 3'b000)) ||
                  ((op == BRANCH) && ((f3 == 3'b010) || (f3 == 3'b011))) ||
                  ((op == REG) && (f7 != 7'b0000000) && (f7 != 7'b0100000)) ||
                  reg_hi_bad;
    end

    imm_gen #(.ARCH(ARCH)) u_imm_gen (
        .instr_in   (instr_in[31:7]),
        .instr_type (raw_type),
        .imm_out    (raw_imm)
    );

    // Build the bundle; fields the format does not use, and everything of an illegal word, read 0.
    always_comb begin
        dec            = '0;
        dec.op_code    = op;
        dec.pc         = pc_in;
        dec.instr_type = TYPE_NONE;
        dec.illegal    = illegal;
        if (!illegal) begin
            dec.instr_type = raw_type;
            dec.imm        = raw_imm;
            if (use_f3)  dec.func3 = f3;
            if (use_f7)  dec.func7 = f7;
            if (use_rs1) dec.rs1   = instr_in[15 +: RW];
            if (use_rs2) dec.rs2   = instr_in[20 +: RW];
            if (use_rd)  dec.rd    = instr_in[7 +: RW];
        end
    end

    assign instr_ready_out = !sk_valid;
    assign accept          = instr_valid_in && instr_ready_out;

    // Output register plus skid entry; flush beats every handshake, a pending skid drains first.
    always_ff @(posedge clk) begin
        if (rst) begin
            or_valid <= 1'b0;
            sk_valid <= 1'b0;
            or_q     <= '0;
            sk_q     <= '0;
        end else if (flush_in) begin
            or_valid <= 1'b0;
            sk_valid <= 1'b0;
        end else if (or_valid && sk_valid && dec_ready_in) begin
            or_q     <= sk_q;
            sk_valid <= 1'b0;
        end else if (accept) begin
            if (!or_valid || dec_ready_in) begin
                or_q     <= dec;
                or_valid <= 1'b1;
            end else begin
                sk_q     <= dec;
                sk_valid <= 1'b1;
            end
        end else if (dec_ready_in) begin
            or_valid <= 1'b0;
        end
    end

    assign dec_valid_out  = or_valid;
    assign op_code_out    = or_q.op_code;
    assign func3_out      = or_q.func3;
    assign func7_out      = or_q.func7;
    assign rs1_out        = or_q.rs1;
    assign rs2_out        = or_q.rs2;
    assign rd_out         = or_q.rd;
    assign imm_out        = or_q.imm;
    assign instr_type_out = or_q.instr_type;
    assign illegal_out    = or_q.illegal;
    assign pc_out         = or_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vectors, expected bundles queued at issue, monitor pops on transfer.
module tb_decode_stage;
    import friscv_pkg::*;

    localparam int W = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_in;
    logic        instr_valid_in;
    logic        instr_ready_out;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        dec_valid_out;
    logic        dec_ready_in;
    logic [6:0]  op_code_out;
    logic [2:0]  func3_out;
    logic [6:0]  func7_out;
    logic [4:0]  rs1_out, rs2_out, rd_out;
    logic [31:0] imm_out;
    instr_type_t instr_type_out;
    logic        illegal_out;
    logic [31:0] pc_out;

    logic        ready_e, valid_e;
    logic [6:0]  op_e, f7_e;
    logic [2:0]  f3_e;
    logic [3:0]  rs1_e, rs2_e, rd_e;
    logic [31:0] imm_e, pc_e;
    instr_type_t type_e;
    logic        illegal_e;

    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    decode_stage #(.ARCH(32), .REGFILE_DEPTH(32)) dut (
        .clk(clk), .rst(rst), .flush_in(flush_in),
        .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
        .instr_in(instr_in), .pc_in(pc_in),
        .dec_valid_out(dec_valid_out), .dec_ready_in(dec_ready_in),
        .op_code_out(op_code_out), .func3_out(func3_out), .func7_out(func7_out),
        .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out),
        .imm_out(imm_out), .instr_type_out(instr_type_out),
        .illegal_out(illegal_out), .pc_out(pc_out)
    );

    decode_stage #(.ARCH(32), .REGFILE_DEPTH(16)) dut_e (
        .clk(clk), .rst(rst), .flush_in(flush_in),
        .instr_valid_in(instr_valid_in), .instr_ready_out(ready_e),
        .instr_in(instr_in), .pc_in(pc_in),
        .dec_valid_out(valid_e), .dec_ready_in(dec_ready_in),
        .op_code_out(op_e), .func3_out(f3_e), .func7_out(f7_e),
        .rs1_out(rs1_e), .rs2_out(rs2_e), .rd_out(rd_e),
        .imm_out(imm_e), .instr_type_out(type_e),
        .illegal_out(illegal_e), .pc_out(pc_e)
    );

    // Clock.
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [4:0] rd,
                                          input logic [31:0] imm, input instr_type_t t,
                                          input logic ill, input logic [31:0] pc);
        logic [2:0] tv;
        tv = t;
        return {op, f3, f7, rs1, rs2, rd, imm, tv, ill, pc};
    endfunction

    function automatic logic [W-1:0] act_bundle();
        return pack(op_code_out, func3_out, func7_out, rs1_out, rs2_out, rd_out,
                    imm_out, instr_type_out, illegal_out, pc_out);
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one instruction starting at a negedge; the expected bundle is queued at acceptance.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [W-1:0] exp);
        int waits;
        instr_valid_in = 1'b1;
        instr_in       = instr;
        pc_in          = pc;
        waits          = 0;
        while (!instr_ready_out && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!instr_ready_out) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: ready stayed %b for instr %h, required 1", instr_ready_out, instr);
        end else begin
            exp_q.push_back(exp);
        end
        @(negedge clk);
        instr_valid_in = 1'b0;
    endtask

    // Scoreboard monitor: compare every bundle that transfers downstream against the queue head.
    always @(negedge clk) begin
        logic [W-1:0] e;
        #2;
        if (!rst && !flush_in && dec_valid_out && dec_ready_in) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_bundle: got %h expected none", act_bundle());
            end else begin
                e = exp_q.pop_front();
                chk("bundle", act_bundle(), e);
            end
        end
    end

    initial begin
        int waits;
        rst = 1'b1; flush_in = 1'b0; instr_valid_in = 1'b0;
        instr_in = '0; pc_in = '0; dec_ready_in = 1'b1;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("reset_valid", W'(dec_valid_out), W'(1'b0));
        chk("reset_ready", W'(instr_ready_out), W'(1'b1));
        chk("reset_data", act_bundle(), '0);
        rst = 1'b0;
        @(negedge clk);

        // Directed decode vectors, downstream always ready.
        send(32'hFFF10093, 32'h100, pack(7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd1, 32'hFFFFFFFF, TYPE_I, 1'b0, 32'h100));
        send(32'hFE000EE3, 32'h104, pack(7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, TYPE_B, 1'b0, 32'h104));
        send(32'h123452B7, 32'h108, pack(7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h12345000, TYPE_U, 1'b0, 32'h108));
        send(32'h001000EF, 32'h10C, pack(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h00000800, TYPE_J, 1'b0, 32'h10C));
        send(32'h002081B3, 32'h110, pack(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0, TYPE_R, 1'b0, 32'h110));
        send(32'h407302B3, 32'h114, pack(7'h33, 3'd0, 7'h20, 5'd6, 5'd7, 5'd5, 32'h0, TYPE_R, 1'b0, 32'h114));
        send(32'h0020A423, 32'h118, pack(7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 32'h8, TYPE_S, 1'b0, 32'h118));
        send(32'hFFC1A203, 32'h11C, pack(7'h03, 3'd2, 7'h00, 5'd3, 5'd0, 5'd4, 32'hFFFFFFFC, TYPE_I, 1'b0, 32'h11C));
        send(32'h00008067, 32'h120, pack(7'h67, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0, TYPE_I, 1'b0, 32'h120));
        send(32'h00000073, 32'h124, pack(7'h73, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, TYPE_I, 1'b0, 32'h124));
        send(32'h00000000, 32'h128, pack(7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, TYPE_NONE, 1'b1, 32'h128));
        send(32'h000000FF, 32'h12C, pack(7'h7F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, TYPE_NONE, 1'b1, 32'h12C));
        send(32'h00009067, 32'h130, pack(7'h67, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, TYPE_NONE, 1'b1, 32'h130));
        send(32'h00002063, 32'h134, pack(7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, TYPE_NONE, 1'b1, 32'h134));
        send(32'h022081B3, 32'h138, pack(7'h33, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, TYPE_NONE, 1'b1, 32'h138));
        send(32'h00208833, 32'h13C, pack(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd16, 32'h0, TYPE_R, 1'b0, 32'h13C));
        // The RV32E instance sees the same word; x16 is out of range there.
        chk("rv32e_x16_illegal", W'({valid_e, illegal_e, type_e, op_e, imm_e, pc_e}),
            W'({1'b1, 1'b1, TYPE_NONE, 7'h33, 32'h0, 32'h13C}));
        repeat (2) @(negedge clk);

        // Back-pressure: four back-to-back instructions, downstream stalls 3 cycles from cycle 2.
        fork
            begin
                send(32'h00100093, 32'h200, pack(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h1, TYPE_I, 1'b0, 32'h200));
                send(32'h00200113, 32'h204, pack(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd2, 32'h2, TYPE_I, 1'b0, 32'h204));
                send(32'h00300193, 32'h208, pack(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd3, 32'h3, TYPE_I, 1'b0, 32'h208));
                send(32'h00400213, 32'h20C, pack(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd4, 32'h4, TYPE_I, 1'b0, 32'h20C));
            end
            begin
                repeat (2) @(negedge clk);
                dec_ready_in = 1'b0;
                repeat (2) @(negedge clk);
                #2;
                chk("stall_ready_low", W'(instr_ready_out), W'(1'b0));
                chk("stall_out_held", act_bundle(),
                    pack(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd2, 32'h2, TYPE_I, 1'b0, 32'h204));
                @(negedge clk);
                dec_ready_in = 1'b1;
                @(negedge clk);
                #2;
                chk("stall_ready_back", W'(instr_ready_out), W'(1'b1));
            end
        join
        repeat (3) @(negedge clk);

        // Flush with both output register and skid entry full.
        dec_ready_in = 1'b0;
        send(32'h00100093, 32'h300, pack(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h1, TYPE_I, 1'b0, 32'h300));
        send(32'h00200113, 32'h304, pack(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd2, 32'h2, TYPE_I, 1'b0, 32'h304));
        chk("flush_pre_full", W'({dec_valid_out, instr_ready_out}), W'(2'b10));
        flush_in = 1'b1;
        @(negedge clk);
        flush_in = 1'b0;
        exp_q.delete();
        chk("flush_empty", W'({dec_valid_out, instr_ready_out}), W'(2'b01));
        // An instruction accepted alongside flush is dropped.
        flush_in = 1'b1; instr_valid_in = 1'b1; instr_in = 32'h00500293; pc_in = 32'h308;
        @(negedge clk);
        flush_in = 1'b0; instr_valid_in = 1'b0;
        chk("flush_drops_accept", W'(dec_valid_out), W'(1'b0));
        dec_ready_in = 1'b1;
        send(32'h00500293, 32'h30C, pack(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h5, TYPE_I, 1'b0, 32'h30C));
        repeat (2) @(negedge clk);

        // Reset with traffic in flight.
        instr_valid_in = 1'b1; instr_in = 32'h00100093; pc_in = 32'h400;
        @(negedge clk);
        instr_in = 32'h00200113; pc_in = 32'h404; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; instr_valid_in = 1'b0;
        chk("midreset_ctrl", W'({dec_valid_out, instr_ready_out}), W'(2'b01));
        chk("midreset_data", act_bundle(), '0);
        repeat (3) @(negedge clk);
        chk("midreset_no_stale", W'(dec_valid_out), W'(1'b0));

        // Drain and confirm nothing is outstanding.
        waits = 0;
        while (exp_q.size() != 0 && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        chk("queue_drained", W'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required finish");
        $fatal(1);
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined, parametrised RV32I/RV32E instruction decode stage between the fetch unit and the register-file/execute stage. Accepts one fetched instruction plus PC per cycle over a valid/ready handshake and splits it into opcode, func fields and register indices. Produces a correctly sign-extended and shifted immediate for every base format, plus a format tag and an illegal-instruction flag. Registered outputs with a one-entry skid buffer give full throughput under back-pressure; a flush input discards in-flight work on redirect.

## Interface
- ARCH, 32: datapath width (32 or 64); immediate and PC width.
- REGFILE_DEPTH, 32: architectural registers (32 = RV32I, 16 = RV32E); index width $clog2(REGFILE_DEPTH).
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush_in  in  1  discard output register and skid buffer.
- instr_valid_in  in  1  fetch presents instr_in/pc_in.
- instr_ready_out  out  1  stage can accept.
- instr_in  in  32  raw instruction word.
- pc_in  in  ARCH  instruction address.
- dec_valid_out  out  1  decoded bundle valid.
- dec_ready_in  in  1  downstream accepts bundle.
- op_code_out  out  7; func3_out  out  3; func7_out  out  7.
- rs1_out, rs2_out, rd_out  out  $clog2(REGFILE_DEPTH) each.
- imm_out  out  ARCH  final immediate.
- instr_type_out  out  instr_type_t  R/I/S/B/U/J/NONE.
- illegal_out  out  1  bundle is an illegal instruction.
- pc_out  out  ARCH  PC of bundle.

## Operation
- Opcode classes: REG 0110011 (R); IMM_ARITH 0010011, IMM_LOAD 0000011, IMM_JUMP/JALR 1100111, SYSTEM 1110011, FENCE 0001111 (I); STORE 0100011 (S); BRANCH 1100011 (B); LUI 0110111, AUIPC 0010111 (U); JUMP/JAL 1101111 (J).
- Field extraction: rd=[11:7], rs1=[19:15], rs2=[24:20], func3=[14:12], func7=[31:25]; a field unused by the format is driven 0.
- Immediates, sign-extended from bit 31 to ARCH:
  - I = [31:20].
  - S = {[31:25],[11:7]}.
  - B = {[31],[7],[30:25],[11:8],1'b0}.
  - U = {[31:12],12'b0}.
  - J = {[31],[19:12],[20],[30:21],1'b0}.
  - R = 0.
- Illegal when any of:
  - instr[1:0] != 11.
  - Unknown opcode.
  - JALR func3 != 000.
  - BRANCH func3 is 010 or 011.
  - REG func7 not in {0000000, 0100000}.
  - REGFILE_DEPTH=16 and bit 4 of any used register field is set.
- Illegal bundle: illegal_out=1, instr_type_out=NONE, op_code_out and pc_out kept, all other fields and imm 0.
- Pipeline: output register (OR) plus one skid entry (SK). Decode is combinational on input; the decoded bundle is stored.
  - Accept = instr_valid_in & instr_ready_out.
  - instr_ready_out = !SK.valid (registered).
  - On accept: if !OR.valid or dec_ready_in, write to OR; else write to SK.
  - If dec_ready_in & OR.valid & SK.valid, SK moves to OR and SK empties; a simultaneous accept is impossible because ready is low.
  - dec_valid_out = OR.valid. Outputs hold stable while dec_valid_out & !dec_ready_in.
- flush_in: OR.valid and SK.valid cleared next edge; an input accepted in the same cycle is dropped. flush_in has priority over all handshake actions.

## Timing
- Latency 1 cycle, instr_in to dec_valid_out. Throughput 1/cycle with dec_ready_in held high.
- Reset (sync): OR.valid=SK.valid=0; dec_valid_out=0, instr_ready_out=1, all data outputs 0, instr_type_out=NONE, illegal_out=0.
- Reset asserted mid-stream: state empties next edge; no bundle emitted after.
- Downstream stall: OR holds; the next instruction lands in SK; instr_ready_out drops the cycle after SK fills; no loss, no duplication, order preserved.
- Stall release: OR drains on the ready edge, SK moves to OR the same edge, instr_ready_out rises next cycle.

## Structure
- friscv_pkg: opcode constants (REG, IMM_ARITH, IMM_LOAD, IMM_JUMP, STORE, BRANCH, LUI, AUIPC, JUMP, SYSTEM, FENCE), instr_type_t enum, dec_bundle_t packed struct (fields + imm + pc + type + illegal), ARCH, REGFILE_DEPTH.
- Sub-module imm_gen: combinational, instr_in + type → ARCH-wide immediate. The decode classifier and skid control stay in decode_stage.

## Test plan
- 0xFFF10093 (addi x1,x2,-1), ready high → next cycle type I, rd=1, rs1=2, func3=0, imm=0xFFFFFFFF.
- 0xFE000EE3 (beq x0,x0,-4) → type B, rs1=rs2=0, imm=0xFFFFFFFC; 0x123452B7 (lui x5) → type U, rd=5, imm=0x12345000; 0x001000EF (jal x1) → type J, rd=1, imm=0x00000800.
- Stream of 4 instrs, dec_ready_in low for 3 cycles from cycle 2 → instr_ready_out low while SK full; all 4 emerge in order, none duplicated.
- 0x00000000 and 0x000000FF → illegal_out=1, type NONE, imm=0; REGFILE_DEPTH=16 with add x16,x1,x2 (0x00208833) → illegal_out=1.
- OR and SK both full, flush_in for 1 cycle → dec_valid_out=0 next cycle, instr_ready_out=1, a new instruction decodes normally.
- rst asserted for 1 cycle with valid traffic in flight → all outputs at reset values next cycle; no stale bundle afterwards.
